// File: rtl/mem_pkg.sv
// Shared types and constants for the cache line-fill responder.
package mem_pkg;

  localparam int unsigned LINE_WORDS    = 8;
  localparam int unsigned LINE_OFFSET_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } rsp_state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } stage_t;

  function automatic logic [15:0] line_base(input logic [15:0] addr);
    return {addr[15:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide backing store: one synchronous write port, one combinational read port.
module word_ram #(
  parameter int unsigned MEM_WORDS = 32768,
  localparam int unsigned AW = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side responder: streams an 8-word line per fill request through a
// fixed-latency read pipeline and accepts single-word write-throughs while idle.
module line_fill_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fill_req_i,
  input  logic [15:0] fill_addr_i,
  input  logic        wr_req_i,
  input  logic [15:0] wr_addr_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ack_o,
  output logic        fill_busy_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_addr_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_last_o
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int unsigned CW  = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LastWord = CW'(LINE_WORDS - 1);

  rsp_state_e    state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_ack_q;
  stage_t        pipe_q [LATENCY];
  stage_t        stage_in;

  logic          wr_en;
  logic [15:0]   issue_addr;
  logic [15:0]   rd_data;
  stage_t        pipe_out;

  assign pipe_out   = pipe_q[LATENCY-1];
  // A write in the same idle cycle as a fill request wins; the fill waits a cycle.
  assign wr_en      = (state_q == StIdle) && wr_req_i;
  assign issue_addr = base_q + {{(15 - CW){1'b0}}, cnt_q, 1'b0};

  word_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_word_ram (
    .clk_i  (clk_i),
    .we_i   (wr_en),
    .waddr_i(wr_addr_i[AW:1]),
    .wdata_i(wr_data_i),
    .raddr_i(issue_addr[AW:1]),
    .rdata_o(rd_data)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (fill_req_i && !wr_req_i) begin
          base_d  = line_base(fill_addr_i);
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastWord) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_out.valid && pipe_out.last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stage_in = '0;
    if (state_q == StIssue) begin
      stage_in.valid = 1'b1;
      stage_in.addr  = issue_addr;
      stage_in.data  = rd_data;
      stage_in.last  = (cnt_q == LastWord);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      base_q   <= '0;
      cnt_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      wr_ack_q <= wr_en;
    end
  end

  // Whole stages are cleared so rsp_addr/rsp_data also read 0 under reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_in;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign wr_ack_o    = wr_ack_q;
  assign fill_busy_o = (state_q != StIdle);
  assign rsp_valid_o = pipe_out.valid;
  assign rsp_addr_o  = pipe_out.addr;
  assign rsp_data_o  = pipe_out.data;
  assign rsp_last_o  = pipe_out.last;

  logic unused_bits;
  assign unused_bits = ^{fill_addr_i[3:0], wr_addr_i[0], issue_addr[0]};

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: two instances, LATENCY=4 and LATENCY=1.
module tb_line_fill_responder;

  logic        clk;
  logic        rst;
  logic        fill_req0, fill_req1;
  logic [15:0] fill_addr0, fill_addr1;
  logic        wr_req;
  logic [15:0] wr_addr, wr_data;

  logic        wr_ack0, busy0, valid0, last0;
  logic [15:0] addr0, data0;
  logic        wr_ack1, busy1, valid1, last1;
  logic [15:0] addr1, data1;

  int unsigned ntot;
  int unsigned nfail;
  logic [15:0] exp_w [8];

  line_fill_responder #(.LATENCY(4), .MEM_WORDS(32768)) dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .fill_req_i (fill_req0),
    .fill_addr_i(fill_addr0),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ack_o   (wr_ack0),
    .fill_busy_o(busy0),
    .rsp_valid_o(valid0),
    .rsp_addr_o (addr0),
    .rsp_data_o (data0),
    .rsp_last_o (last0)
  );

  // Shares the write port so its store holds the same data as dut0.
  line_fill_responder #(.LATENCY(1), .MEM_WORDS(32768)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .fill_req_i (fill_req1),
    .fill_addr_i(fill_addr1),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ack_o   (wr_ack1),
    .fill_busy_o(busy1),
    .rsp_valid_o(valid1),
    .rsp_addr_o (addr1),
    .rsp_data_o (data1),
    .rsp_last_o (last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) exp_w[i] = 16'h0000;
  endtask

  // {busy, valid, last, addr, data}
  function automatic logic [34:0] rsp(input bit sel);
    if (sel) return {busy1, valid1, last1, addr1, data1};
    return {busy0, valid0, last0, addr0, data0};
  endfunction

  // Called just after the accepting edge E0; walks to cycle E0+lat+8.
  task automatic check_line(input bit sel, input logic [15:0] base, input int lat);
    logic [34:0] r;
    int k;
    r = rsp(sel);
    chk("busy_after_accept", {31'd0, r[34]}, 32'd1);
    for (int n = 1; n <= lat + 8; n++) begin
      step();
      r = rsp(sel);
      if (n >= lat && n <= lat + 7) begin
        k = n - lat;
        chk("rsp_valid", {31'd0, r[33]}, 32'd1);
        chk("rsp_addr", {16'd0, r[31:16]}, {16'd0, base + 16'(2 * k)});
        chk("rsp_data", {16'd0, r[15:0]}, {16'd0, exp_w[k]});
        chk("rsp_last", {31'd0, r[32]}, (k == 7) ? 32'd1 : 32'd0);
      end else begin
        chk("rsp_idle_valid", {31'd0, r[33]}, 32'd0);
      end
    end
    chk("busy_after_line", {31'd0, r[34]}, 32'd0);
  endtask

  initial begin
    int n;
    ntot = 0;
    nfail = 0;
    rst = 1'b0;
    fill_req0 = 1'b0; fill_addr0 = 16'h0000;
    fill_req1 = 1'b0; fill_addr1 = 16'h0000;
    wr_req = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;

    // Reset state, observed before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("reset_wr_ack", {31'd0, wr_ack0}, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_valid", {31'd0, valid0}, 32'd0);
    chk("reset_addr", {16'd0, addr0}, 32'd0);
    chk("reset_data", {16'd0, data0}, 32'd0);
    chk("reset_last", {31'd0, last0}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("busy_after_release", {31'd0, busy0}, 32'd0);

    // Write 0x1234 to 0x0024, then fill from 0x0026
    wr_req = 1'b1; wr_addr = 16'h0024; wr_data = 16'h1234;
    step();
    wr_req = 1'b0;
    chk("wr_ack_pulse", {31'd0, wr_ack0}, 32'd1);
    step();
    chk("wr_ack_single", {31'd0, wr_ack0}, 32'd0);
    clear_exp();
    exp_w[2] = 16'h1234;
    fill_req0 = 1'b1; fill_addr0 = 16'h0026;
    step();
    fill_req0 = 1'b0;
    check_line(1'b0, 16'h0020, 4);

    // Same-cycle fill and write: write first, fill one cycle later
    fill_req0 = 1'b1; fill_addr0 = 16'h0040;
    wr_req = 1'b1; wr_addr = 16'h0042; wr_data = 16'hBEEF;
    step();
    wr_req = 1'b0;
    chk("collide_wr_ack", {31'd0, wr_ack0}, 32'd1);
    chk("collide_busy", {31'd0, busy0}, 32'd0);
    step();
    fill_req0 = 1'b0;
    chk("collide_wr_ack_clear", {31'd0, wr_ack0}, 32'd0);
    clear_exp();
    exp_w[1] = 16'hBEEF;
    check_line(1'b0, 16'h0040, 4);

    // Write held across a fill is deferred until fill_busy falls
    fill_req0 = 1'b1; fill_addr0 = 16'h0040;
    step();
    fill_req0 = 1'b0;
    wr_req = 1'b1; wr_addr = 16'h0046; wr_data = 16'h5A5A;
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      step();
      n++;
      chk("held_wr_no_ack", {31'd0, wr_ack0}, 32'd0);
    end
    chk("busy_fall_cycle", n, 32'd12);
    step();
    wr_req = 1'b0;
    chk("held_wr_ack", {31'd0, wr_ack0}, 32'd1);
    step();
    chk("held_wr_ack_single", {31'd0, wr_ack0}, 32'd0);
    clear_exp();
    exp_w[1] = 16'hBEEF;
    exp_w[3] = 16'h5A5A;
    fill_req0 = 1'b1; fill_addr0 = 16'h0040;
    step();
    fill_req0 = 1'b0;
    check_line(1'b0, 16'h0040, 4);

    // Reset in cycle E0+6 aborts the line
    fill_req0 = 1'b1; fill_addr0 = 16'h0020;
    step();
    fill_req0 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_abort_valid", {31'd0, valid0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, valid0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_addr", {16'd0, addr0}, 32'd0);
    chk("abort_data", {16'd0, data0}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_abort_valid", {31'd0, valid0}, 32'd0);
    end
    clear_exp();
    exp_w[2] = 16'h1234;
    fill_req0 = 1'b1; fill_addr0 = 16'h0020;
    step();
    fill_req0 = 1'b0;
    check_line(1'b0, 16'h0020, 4);

    // Seed two lines, then fill_req held across both
    wr_req = 1'b1; wr_addr = 16'h0104; wr_data = 16'h1111;
    step();
    wr_addr = 16'h011E; wr_data = 16'h2222;
    step();
    wr_req = 1'b0;
    chk("seed_wr_ack", {31'd0, wr_ack0}, 32'd1);
    step();
    chk("seed_wr_ack_clear", {31'd0, wr_ack0}, 32'd0);

    fill_req0 = 1'b1; fill_addr0 = 16'h0100;
    step();
    fill_addr0 = 16'h0110;
    clear_exp();
    exp_w[2] = 16'h1111;
    check_line(1'b0, 16'h0100, 4);
    step();
    fill_req0 = 1'b0;
    clear_exp();
    exp_w[7] = 16'h2222;
    check_line(1'b0, 16'h0110, 4);

    // Same back-to-back pattern on the LATENCY=1 instance
    fill_req1 = 1'b1; fill_addr1 = 16'h0100;
    step();
    fill_addr1 = 16'h0110;
    clear_exp();
    exp_w[2] = 16'h1111;
    check_line(1'b1, 16'h0100, 1);
    step();
    fill_req1 = 1'b0;
    clear_exp();
    exp_w[7] = 16'h2222;
    check_line(1'b1, 16'h0110, 1);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
